// File: rtl/uart_rx_depacketizer.sv
// uart_rx_depacketizer
//
// Receive-side UART framer. Recovers 10-bit frames (start 0, eight data bits
// LSB first, stop 1) from the serial line and pushes each good byte into the
// RX FIFO write port. Framing errors and FIFO overruns are reported as
// single-cycle pulses and accumulated in a saturating error counter.
//
// Ports:
//   i_clk          system clock, everything on the rising edge
//   i_rst          synchronous active-high reset
//   i_rx           asynchronous serial input, idles high
//   i_fifo_full    RX FIFO full flag, looked at in the write cycle
//   o_fifo_wr_en   one-cycle write strobe to the RX FIFO
//   o_fifo_wr_data received byte, valid with o_fifo_wr_en, otherwise holds
//   o_rx_busy      high whenever the receiver is not idle
//   o_frame_err    one-cycle pulse when the stop bit samples low
//   o_overrun      one-cycle pulse when a good byte is dropped (FIFO full)
//   o_err_count    saturating count of framing errors plus overruns

module uart_rx_depacketizer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_fifo_full,
  output logic       o_fifo_wr_en,
  output logic [7:0] o_fifo_wr_data,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic [7:0] o_err_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WRITE,
    ST_WAIT_IDLE
  } rxState_t;

  rxState_t         r_state;
  logic             r_rxMeta;
  logic             r_rxSync;
  logic [CNT_W-1:0] r_cycleCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_fifoWrEn;
  logic [7:0]       r_fifoWrData;
  logic             r_frameErr;
  logic             r_overrun;
  logic [7:0]       r_errCount;

  logic w_rxS;
  logic w_errSat;

  assign w_rxS    = r_rxSync;
  assign w_errSat = (r_errCount == 8'hFF);

  // Two-flop synchronizer for the asynchronous line. Both stages reset to the
  // idle (high) level so a reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= i_rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // Receive state machine. The start bit is re-checked at its midpoint to
  // reject glitches; after that every sample lands one full bit period later,
  // i.e. in the middle of each data bit and of the stop bit. The three strobes
  // default low every cycle so each one can only ever last a single cycle.
  // After a bad stop bit the machine waits for the line to return high so a
  // held-low break cannot be mistaken for a fresh start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cycleCnt   <= '0;
      r_bitIdx     <= '0;
      r_shift      <= '0;
      r_fifoWrEn   <= 1'b0;
      r_fifoWrData <= '0;
      r_frameErr   <= 1'b0;
      r_overrun    <= 1'b0;
      r_errCount   <= '0;
    end else begin
      r_fifoWrEn <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_rxS) begin
            r_state    <= ST_START;
            r_cycleCnt <= '0;
          end
        end

        ST_START: begin
          if (r_cycleCnt == HALF_LAST) begin
            r_cycleCnt <= '0;
            if (!w_rxS) begin
              r_state  <= ST_DATA;
              r_bitIdx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (r_cycleCnt == BIT_LAST) begin
            r_cycleCnt        <= '0;
            r_shift[r_bitIdx] <= w_rxS;
            r_bitIdx          <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (r_cycleCnt == BIT_LAST) begin
            r_cycleCnt <= '0;
            if (w_rxS) begin
              r_state <= ST_WRITE;
            end else begin
              r_state    <= ST_WAIT_IDLE;
              r_frameErr <= 1'b1;
              if (!w_errSat) begin
                r_errCount <= r_errCount + 8'd1;
              end
            end
          end else begin
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
          end
        end

        ST_WRITE: begin
          r_state <= ST_IDLE;
          if (!i_fifo_full) begin
            r_fifoWrEn   <= 1'b1;
            r_fifoWrData <= r_shift;
          end else begin
            r_overrun <= 1'b1;
            if (!w_errSat) begin
              r_errCount <= r_errCount + 8'd1;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (w_rxS) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_wr_en   = r_fifoWrEn;
  assign o_fifo_wr_data = r_fifoWrData;
  assign o_rx_busy      = (r_state != ST_IDLE);
  assign o_frame_err    = r_frameErr;
  assign o_overrun      = r_overrun;
  assign o_err_count    = r_errCount;

endmodule

// File: tb/tb_uart_rx_depacketizer.sv
// tb_uart_rx_depacketizer
//
// Self-checking bench for uart_rx_depacketizer at 16 clocks per bit. Frames
// are driven on the serial line; a reference model predicts, per frame, the
// outcome (byte written, framing error or overrun) and the saturating error
// count. A negedge monitor records every strobe the DUT produces and flags any
// overlap or stretched pulse.
//
// Ports: none (top-level bench).

module tb_uart_rx_depacketizer;

  localparam int CPB       = 16;
  localparam int HALF      = CPB / 2;
  localparam int WRITE_LAT = 3 + HALF + 9 * CPB + 1;

  localparam int EV_WRITE = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_OVR   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       fifoFull;
  logic       fifoWrEn;
  logic [7:0] fifoWrData;
  logic       rxBusy;
  logic       frameErr;
  logic       overrun;
  logic [7:0] errCount;

  int checkCount = 0;
  int passCount  = 0;
  int cycleCnt   = 0;
  int startCycle = 0;
  int expErrCount = 0;
  int strobeViolations = 0;

  int         obsKind[$];
  logic [7:0] obsData[$];
  int         obsCycle[$];
  int         expKind[$];
  logic [7:0] expData[$];

  logic prevWr = 1'b0;
  logic prevFe = 1'b0;
  logic prevOv = 1'b0;

  uart_rx_depacketizer #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx           (rx),
    .i_fifo_full    (fifoFull),
    .o_fifo_wr_en   (fifoWrEn),
    .o_fifo_wr_data (fifoWrData),
    .o_rx_busy      (rxBusy),
    .o_frame_err    (frameErr),
    .o_overrun      (overrun),
    .o_err_count    (errCount)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Cycle counter used to time the write strobe against the start edge.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Monitor: log every strobe on the falling edge and count any cycle where
  // two strobes overlap or a strobe stays high for a second cycle.
  always @(negedge clk) begin
    if (fifoWrEn === 1'b1) begin
      obsKind.push_back(EV_WRITE);
      obsData.push_back(fifoWrData);
      obsCycle.push_back(cycleCnt);
    end
    if (frameErr === 1'b1) begin
      obsKind.push_back(EV_FERR);
      obsData.push_back(8'h00);
      obsCycle.push_back(cycleCnt);
    end
    if (overrun === 1'b1) begin
      obsKind.push_back(EV_OVR);
      obsData.push_back(8'h00);
      obsCycle.push_back(cycleCnt);
    end
    if (((int'(fifoWrEn) + int'(frameErr) + int'(overrun)) > 1) ||
        (fifoWrEn && prevWr) || (frameErr && prevFe) || (overrun && prevOv)) begin
      strobeViolations <= strobeViolations + 1;
    end
    prevWr <= fifoWrEn;
    prevFe <= frameErr;
    prevOv <= overrun;
  end

  // Watchdog so the run can never hang.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one bit period; entered and left just after a rising edge.
  task automatic driveBit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Hold the line idle for n clocks.
  task automatic idleLine(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame either yields its byte, a framing error or an
  // overrun; errors bump a counter that sticks at 255.
  task automatic modelFrame(input logic [7:0] data, input logic stopBit, input logic full);
    if (!stopBit) begin
      expKind.push_back(EV_FERR);
      expData.push_back(8'h00);
      expErrCount = (expErrCount < 255) ? expErrCount + 1 : 255;
    end else if (full) begin
      expKind.push_back(EV_OVR);
      expData.push_back(8'h00);
      expErrCount = (expErrCount < 255) ? expErrCount + 1 : 255;
    end else begin
      expKind.push_back(EV_WRITE);
      expData.push_back(data);
    end
  endtask

  // Send one complete frame and record what the model expects from it.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic full);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    modelFrame(data, stopBit, full);
    fifoFull = full;
    startCycle = cycleCnt;
    for (int i = 0; i < 10; i++) begin
      driveBit(frame[i]);
    end
  endtask

  // Compare observed strobes against the model, then clear both logs.
  task automatic compareEvents(input string tag);
    int n;
    checkOutput({tag, ".count"}, obsKind.size(), expKind.size());
    n = (obsKind.size() < expKind.size()) ? obsKind.size() : expKind.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".kind"}, obsKind[i], expKind[i]);
      if (expKind[i] == EV_WRITE) begin
        checkOutput({tag, ".data"}, obsData[i], expData[i]);
      end
    end
    checkOutput({tag, ".errCount"}, errCount, expErrCount);
    checkOutput({tag, ".busy"}, rxBusy, 1'b0);
    obsKind.delete();
    obsData.delete();
    obsCycle.delete();
    expKind.delete();
    expData.delete();
  endtask

  // Main sequence.
  initial begin
    logic [9:0] cutFrame;
    logic [7:0] rnd;
    logic       stopOk;
    logic       full;

    rst = 1'b1;
    rx = 1'b1;
    fifoFull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.wrEn", fifoWrEn, 1'b0);
    checkOutput("reset.wrData", fifoWrData, 8'h00);
    checkOutput("reset.busy", rxBusy, 1'b0);
    checkOutput("reset.frameErr", frameErr, 1'b0);
    checkOutput("reset.overrun", overrun, 1'b0);
    checkOutput("reset.errCount", errCount, 8'h00);
    rst = 1'b0;
    idleLine(10);

    applyStimulus(8'h55, 1'b1, 1'b0);
    idleLine(20);
    checkOutput("single.latency", (obsCycle.size() > 0) ? obsCycle[0] - startCycle : -1, WRITE_LAT);
    compareEvents("single");

    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    idleLine(20);
    compareEvents("b2b");

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idleLine(30);
    compareEvents("glitch");
    applyStimulus(8'h3C, 1'b1, 1'b0);
    idleLine(20);
    compareEvents("glitchNext");

    applyStimulus(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idleLine(30);
    compareEvents("framing");
    applyStimulus(8'h12, 1'b1, 1'b0);
    idleLine(20);
    compareEvents("framingNext");

    for (int f = 0; f < 24; f++) begin
      rnd    = 8'($urandom);
      stopOk = ($urandom_range(0, 5) != 0);
      full   = ($urandom_range(0, 3) == 0);
      applyStimulus(rnd, stopOk, full);
      if (!stopOk) begin
        idleLine(8 + int'($urandom_range(0, 10)));
      end else begin
        idleLine(int'($urandom_range(0, 10)));
      end
    end
    fifoFull = 1'b0;
    idleLine(30);
    compareEvents("random");

    cutFrame = {1'b1, 8'hC6, 1'b0};
    for (int i = 0; i < 5; i++) begin
      driveBit(cutFrame[i]);
    end
    rx = cutFrame[5];
    repeat (HALF) @(posedge clk);
    #1;
    checkOutput("rstMid.busyBefore", rxBusy, 1'b1);
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstMid.busy", rxBusy, 1'b0);
    checkOutput("rstMid.wrEn", fifoWrEn, 1'b0);
    checkOutput("rstMid.wrData", fifoWrData, 8'h00);
    checkOutput("rstMid.errCount", errCount, 8'h00);
    rst = 1'b0;
    expErrCount = 0;
    idleLine(40);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    idleLine(20);
    compareEvents("afterReset");

    applyStimulus(8'h7E, 1'b1, 1'b1);
    idleLine(10);
    compareEvents("overrunFirst");
    for (int f = 0; f < 299; f++) begin
      applyStimulus(8'($urandom), 1'b1, 1'b1);
    end
    fifoFull = 1'b0;
    idleLine(20);
    compareEvents("saturate");
    checkOutput("saturate.errMax", errCount, 8'hFF);

    checkOutput("strobeRules", strobeViolations, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_depacketizer.md
Name: uart_rx_depacketizer

Overview:
- Receive-side counterpart of the TX packetizer. Recovers 10-bit UART frames from the serial line and writes the 8 data bits into the RX FIFO.
- Frame format, LSB-first on the wire: start bit (0), data[0..7], stop bit (1). This matches the {stop, data, start} word the TX path shifts out.
- Sits between the board RX pin and the RX FIFO write port. Detects framing errors and FIFO overruns and reports both.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200). Legal values are 4 or more.
- HALF_BIT, CLKS_PER_BIT/2 (integer floor), cycles from start-edge detect to the start-bit mid-sample.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- fifo_full  in  1  RX FIFO full flag, sampled in the write cycle.
- fifo_wr_en  out  1  single-cycle write strobe to the RX FIFO.
- fifo_wr_data  out  8  received byte; valid while fifo_wr_en=1, holds its last value otherwise.
- rx_busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  single-cycle pulse when the stop bit samples 0.
- overrun  out  1  single-cycle pulse when a good frame is dropped because fifo_full=1.
- err_count  out  8  saturating count of frame_err plus overrun events.

Behaviour:
- Synchronizer:
  - rx passes through two flops; rx_s is the second stage. All decisions use rx_s only.
  - Both flops reset to 1.
- Reset values (rst=1 at a rising edge):
  - state=IDLE; bit counter, cycle counter and shift register = 0.
  - fifo_wr_en=0, fifo_wr_data=0, frame_err=0, overrun=0, err_count=0, rx_busy=0.
  - Reset mid-frame abandons the frame with no write and no error pulse.
- FSM states: IDLE, START, DATA, STOP, WRITE, WAIT_IDLE.
- IDLE:
  - rx_s=0 moves to START and clears the cycle counter.
- START:
  - Counts to HALF_BIT-1, then samples rx_s.
  - rx_s=0: move to DATA, clear the cycle counter, bit_idx=0.
  - rx_s=1: glitch; return to IDLE with no pulse.
- DATA:
  - Counts to CLKS_PER_BIT-1, then samples rx_s into shift[bit_idx]. The first data bit received is the LSB.
  - bit_idx increments after each sample. After the sample at bit_idx=7, move to STOP.
- STOP:
  - Counts to CLKS_PER_BIT-1, then samples rx_s.
  - rx_s=1: move to WRITE.
  - rx_s=0: assert frame_err for exactly 1 cycle, increment err_count, move to WAIT_IDLE. The byte is discarded.
- WRITE (one cycle):
  - fifo_full=0: fifo_wr_en=1 and fifo_wr_data=shift.
  - fifo_full=1: overrun=1 and err_count increments; no write.
  - Always returns to IDLE on the next cycle.
- WAIT_IDLE:
  - Stays until rx_s=1, then moves to IDLE. This prevents a break condition (line held low) from retriggering as a start bit.
- Counters and widths:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits. bit_idx is 3 bits.
  - err_count saturates at 255 and never wraps.
- Latency:
  - fifo_wr_en asserts exactly 1 cycle after the stop-bit sample.
  - Stop sample falls HALF_BIT + 9*CLKS_PER_BIT cycles after START is entered.
  - START is entered 3 cycles after rx falls at the pin: 2 synchronizer cycles plus the IDLE detect.
- Back-to-back frames:
  - A new start edge is accepted on the first IDLE cycle after WRITE.
  - This tolerates the next start bit arriving immediately after a full-length stop bit.
- Strobe rules:
  - fifo_wr_en, frame_err and overrun are mutually exclusive and never high for more than 1 consecutive cycle.

Test Plan:
- Single frame, CLKS_PER_BIT=16, drive byte 0x55 LSB-first at 16 clk/bit with fifo_full=0 → one fifo_wr_en pulse with fifo_wr_data=0x55, 1 cycle after the stop sample; err_count=0.
- Back-to-back frames 0xA3, 0x00, 0xFF with no idle gap → exactly three writes in order 0xA3, 0x00, 0xFF, each 1 cycle wide, no error pulses.
- Glitch: drive rx low for 4 clks then high → no write, no frame_err, rx_busy returns to 0; the next valid frame 0x3C is received correctly.
- Framing error: send 0x81 with stop bit 0, then hold rx low for 40 clks, then high → one frame_err pulse, err_count=1, no write, no spurious start while low; a following frame 0x12 is written correctly.
- Overrun: fifo_full=1 during frame 0x7E → overrun pulses once, no fifo_wr_en, err_count increments. Repeat 300 times → err_count saturates at 255.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 4 of 0xC6 → all outputs 0 next cycle, no write for that frame; a subsequent 0x5A after line idle is received correctly.
